// File: rtl/mining_bus_pkg.sv
// Shared definitions for the miner's 8-bit register bus:
// register map, job layout and the initiator state encoding.
package mining_bus_pkg;

   localparam logic [6:0] ADDR_STATUS      = 7'd0;
   localparam logic [6:0] ADDR_NONCE0      = 7'd1;
   localparam logic [6:0] ADDR_MIDSTATE0   = 7'd5;
   localparam logic [6:0] ADDR_NEXTINPUT0  = 7'd37;
   localparam logic [6:0] ADDR_DIFFICULTY0 = 7'd49;
   localparam logic [6:0] ADDR_LAST        = 7'd52;

   localparam int JOB_BYTES        = 48;
   localparam int STATUS_FOUND_BIT = 0;

   // Byte 0 of the packed job is midstate[7:0].
   typedef struct packed {
      logic [31:0]  difficulty;
      logic [95:0]  nextInput;
      logic [255:0] midstate;
   } job_t;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      POLL,
      NONCE_RD,
      RESULT
   } state_t;

endpackage

// File: rtl/job_bus_master_if.sv
// Job handshake, register-bus pins and result handshake.
// master: the initiator; slave: job source/responder/consumer.
interface job_bus_master_if;

   logic         job_valid;
   logic         job_ready;
   logic [255:0] job_midstate;
   logic [95:0]  job_next_input;
   logic [31:0]  job_difficulty;
   logic         job_abort;

   logic [6:0]   bus_addr;
   logic [7:0]   bus_wdata;
   logic         bus_wdata_oe;
   logic [7:0]   bus_rdata;

   logic         result_valid;
   logic         result_ready;
   logic [31:0]  result_nonce;
   logic         result_timeout;

   modport master (
      input  job_valid, job_midstate,
      input  job_next_input, job_difficulty,
      input  job_abort, bus_rdata,
      input  result_ready,
      output job_ready, bus_addr,
      output bus_wdata, bus_wdata_oe,
      output result_valid, result_nonce,
      output result_timeout
   );

   modport slave (
      output job_valid, job_midstate,
      output job_next_input, job_difficulty,
      output job_abort, bus_rdata,
      output result_ready,
      input  job_ready, bus_addr,
      input  bus_wdata, bus_wdata_oe,
      input  result_valid, result_nonce,
      input  result_timeout
   );

endinterface

// File: rtl/job_bus_master_access_timer.sv
// bus_access_timer: per-access down-counter; last is high on the
// final cycle of each ACCESS_CYCLES-long access. Ports: clk, rst_n, load, last.
module bus_access_timer #(
   parameter int ACCESS_CYCLES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   output logic last
);

   localparam logic [3:0] RELOAD = 4'(ACCESS_CYCLES - 1);

   logic [3:0] cnt;

   // Auto-reloads so back-to-back accesses need no extra load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= RELOAD;
      else if (load || cnt == 4'd0)
         cnt <= RELOAD;
      else
         cnt <= cnt - 4'd1;
   end

   assign last = (cnt == 4'd0);

endmodule

// File: rtl/job_bus_master.sv
// Register-bus initiator: loads a job (48 bytes), polls status,
// reads the 4-byte nonce, then holds the result until accepted.
// Ports: clk, rst_n, bus (job_bus_master_if.master).
// Optional macro JOB_TIMEOUT_EN: give up after POLL_TIMEOUT polls.
module job_bus_master
   import mining_bus_pkg::*;
#(
   parameter int          ACCESS_CYCLES = 2,
   parameter int          POLL_INTERVAL = 16,
   parameter logic [15:0] POLL_TIMEOUT  = 16'd1024
) (
   input logic               clk,
   input logic               rst_n,
   job_bus_master_if.master  bus
);

   if (ACCESS_CYCLES < 2 || ACCESS_CYCLES > 15 ||
       POLL_INTERVAL < 1 || POLL_TIMEOUT == 16'd0)
   begin : gBadParam
      $error("job_bus_master: illegal parameter");
   end

   localparam logic [15:0] POLL_LAST =
      16'(POLL_INTERVAL - 1);

   state_t      state, stateNext;
   job_t        job, jobNext;
   logic [5:0]  idx, idxNext, idxInc;
   logic [6:0]  addr, addrNext;
   logic [7:0]  wdata, wdataNext;
   logic        oe, oeNext;
   logic [15:0] pollCnt, pollCntNext;
   logic [31:0] nonce, nonceNext;
   logic        resValid, resValidNext;
   logic        timerLoad;
   logic        accessLast;

`ifdef JOB_TIMEOUT_EN
   logic [15:0] sampleCnt, sampleCntNext;
   logic        timeoutQ, timeoutNext;
`endif

   assign idxInc = idx + 6'd1;

   bus_access_timer #(
      .ACCESS_CYCLES(ACCESS_CYCLES)
   ) uTimer (
      .clk  (clk),
      .rst_n(rst_n),
      .load (timerLoad),
      .last (accessLast)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         job      <= '0;
         idx      <= '0;
         addr     <= ADDR_STATUS;
         wdata    <= '0;
         oe       <= 1'b0;
         pollCnt  <= '0;
         nonce    <= '0;
         resValid <= 1'b0;
      end else begin
         state    <= stateNext;
         job      <= jobNext;
         idx      <= idxNext;
         addr     <= addrNext;
         wdata    <= wdataNext;
         oe       <= oeNext;
         pollCnt  <= pollCntNext;
         nonce    <= nonceNext;
         resValid <= resValidNext;
      end
   end

`ifdef JOB_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sampleCnt <= '0;
         timeoutQ  <= 1'b0;
      end else begin
         sampleCnt <= sampleCntNext;
         timeoutQ  <= timeoutNext;
      end
   end
`endif

   // Bus pins default to idle (addr 0, no drive) so any exit
   // from a bus phase parks the responder safely.
   always_comb begin
      stateNext    = state;
      jobNext      = job;
      idxNext      = idx;
      addrNext     = ADDR_STATUS;
      wdataNext    = '0;
      oeNext       = 1'b0;
      pollCntNext  = pollCnt;
      nonceNext    = nonce;
      resValidNext = resValid;
      timerLoad    = 1'b0;
`ifdef JOB_TIMEOUT_EN
      sampleCntNext = sampleCnt;
      timeoutNext   = timeoutQ;
`endif
      unique case (state)
         IDLE: begin
            if (bus.job_valid) begin
               jobNext = '{
                  difficulty: bus.job_difficulty,
                  nextInput:  bus.job_next_input,
                  midstate:   bus.job_midstate
               };
               stateNext = WRITE;
               idxNext   = '0;
               addrNext  = ADDR_MIDSTATE0;
               wdataNext = bus.job_midstate[7:0];
               oeNext    = 1'b1;
               timerLoad = 1'b1;
`ifdef JOB_TIMEOUT_EN
               timeoutNext = 1'b0;
`endif
            end
         end
         WRITE: begin
            if (bus.job_abort) begin
               stateNext = IDLE;
            end else if (!accessLast) begin
               addrNext  = addr;
               wdataNext = wdata;
               oeNext    = 1'b1;
            end else if (idx == 6'(JOB_BYTES - 1)) begin
               stateNext   = POLL;
               pollCntNext = '0;
`ifdef JOB_TIMEOUT_EN
               sampleCntNext = '0;
`endif
            end else begin
               idxNext   = idxInc;
               addrNext  = ADDR_MIDSTATE0 + {1'b0, idxInc};
               wdataNext = job[{idxInc, 3'b000} +: 8];
               oeNext    = 1'b1;
            end
         end
         POLL: begin
            if (bus.job_abort) begin
               stateNext = IDLE;
            end else if (pollCnt != POLL_LAST) begin
               pollCntNext = pollCnt + 16'd1;
            end else begin
               pollCntNext = '0;
               if (bus.bus_rdata[STATUS_FOUND_BIT]) begin
                  stateNext = NONCE_RD;
                  idxNext   = '0;
                  addrNext  = ADDR_NONCE0;
                  nonceNext = '0;
                  timerLoad = 1'b1;
`ifdef JOB_TIMEOUT_EN
               end else if (sampleCnt ==
                            POLL_TIMEOUT - 16'd1) begin
                  stateNext    = RESULT;
                  nonceNext    = '0;
                  resValidNext = 1'b1;
                  timeoutNext  = 1'b1;
               end else begin
                  sampleCntNext = sampleCnt + 16'd1;
`endif
               end
            end
         end
         NONCE_RD: begin
            if (bus.job_abort) begin
               stateNext = IDLE;
            end else if (!accessLast) begin
               addrNext = addr;
            end else begin
               nonceNext[{idx[1:0], 3'b000} +: 8] =
                  bus.bus_rdata;
               if (idx[1:0] == 2'd3) begin
                  stateNext    = RESULT;
                  resValidNext = 1'b1;
               end else begin
                  idxNext  = idxInc;
                  addrNext = ADDR_NONCE0 +
                             {5'b0, idxInc[1:0]};
               end
            end
         end
         RESULT: begin
            if (bus.result_ready) begin
               stateNext    = IDLE;
               resValidNext = 1'b0;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   assign bus.job_ready    = (state == IDLE);
   assign bus.bus_addr     = addr;
   assign bus.bus_wdata    = wdata;
   assign bus.bus_wdata_oe = oe;
   assign bus.result_valid = resValid;
   assign bus.result_nonce = nonce;
`ifdef JOB_TIMEOUT_EN
   assign bus.result_timeout = timeoutQ;
`else
   assign bus.result_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_job_bus_master.sv
// Self-checking bench for job_bus_master: responder model,
// write/result scoreboards, abort, backpressure, reset, timeout.
module tb_job_bus_master;
   import mining_bus_pkg::*;

`ifdef JOB_TIMEOUT_EN
   localparam logic [15:0] PT = 16'd4;
`else
   localparam logic [15:0] PT = 16'd1024;
`endif

   typedef struct {
      logic [6:0] a;
      logic [7:0] d;
   } wr_t;

   typedef struct {
      logic [31:0] n;
      logic        t;
   } res_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic statusFound = 1'b0;
   logic [31:0] nonceVal = '0;
   logic [7:0] mem [0:127];
   wr_t  expWr[$];
   res_t expRes[$];
   logic [6:0] rdLog[$];
   int   wrCount = 0;
   int   checks = 0;
   int   errors = 0;
   logic [6:0] prevAddr = '0;
   logic prevValid = 1'b0;
   job_t jobA, jobB, jobC;

   job_bus_master_if ifc();

   job_bus_master #(
      .ACCESS_CYCLES(2),
      .POLL_INTERVAL(16),
      .POLL_TIMEOUT (PT)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (ifc)
   );

   always #5 clk = ~clk;

   assign ifc.bus_rdata =
      (ifc.bus_addr == ADDR_STATUS) ?
         {7'b0, statusFound} :
      (ifc.bus_addr >= ADDR_NONCE0 &&
       ifc.bus_addr < ADDR_MIDSTATE0) ?
         8'(nonceVal >> (8 * (ifc.bus_addr - 7'd1))) :
         8'h00;

   // Responder: writes whenever the address is in the job window.
   always @(posedge clk) begin
      if (rst_n && ifc.bus_addr >= ADDR_MIDSTATE0 &&
          ifc.bus_addr <= ADDR_LAST)
         mem[ifc.bus_addr] <= ifc.bus_wdata;
   end

   task automatic check(input string tag,
                        input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h",
                  tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      wr_t  w;
      res_t r;
      if (!rst_n) begin
         prevAddr  = '0;
         prevValid = 1'b0;
      end else begin
         if (ifc.bus_addr != prevAddr &&
             ifc.bus_addr >= ADDR_MIDSTATE0 &&
             ifc.bus_addr <= ADDR_LAST) begin
            wrCount++;
            if (expWr.size() == 0) begin
               check("wr_extra", 64'(ifc.bus_addr), 0);
            end else begin
               w = expWr.pop_front();
               check("wr_addr", 64'(ifc.bus_addr), 64'(w.a));
               check("wr_data", 64'(ifc.bus_wdata), 64'(w.d));
               check("wr_oe", 64'(ifc.bus_wdata_oe), 1);
            end
         end
         if (ifc.bus_addr != prevAddr &&
             ifc.bus_addr >= ADDR_NONCE0 &&
             ifc.bus_addr < ADDR_MIDSTATE0)
            rdLog.push_back(ifc.bus_addr);
         if (ifc.result_valid && !prevValid) begin
            if (expRes.size() == 0) begin
               check("res_extra", 64'(ifc.result_valid), 0);
            end else begin
               r = expRes.pop_front();
               check("res_nonce", 64'(ifc.result_nonce), 64'(r.n));
               check("res_tmo", 64'(ifc.result_timeout), 64'(r.t));
            end
         end
         prevAddr  = ifc.bus_addr;
         prevValid = ifc.result_valid;
      end
   end

   task automatic checkReset(input string tag);
      check({tag, "_rdy"}, 64'(ifc.job_ready), 1);
      check({tag, "_addr"}, 64'(ifc.bus_addr), 0);
      check({tag, "_wd"}, 64'(ifc.bus_wdata), 0);
      check({tag, "_oe"}, 64'(ifc.bus_wdata_oe), 0);
      check({tag, "_rv"}, 64'(ifc.result_valid), 0);
      check({tag, "_rn"}, 64'(ifc.result_nonce), 0);
      check({tag, "_rt"}, 64'(ifc.result_timeout), 0);
   endtask

   task automatic driveJob(input job_t j);
      ifc.job_midstate   = j.midstate;
      ifc.job_next_input = j.nextInput;
      ifc.job_difficulty = j.difficulty;
      ifc.job_valid      = 1'b1;
      wrCount = 0;
      rdLog.delete();
      for (int i = 0; i < JOB_BYTES; i++)
         expWr.push_back('{a: 7'(5 + i), d: j[8*i +: 8]});
   endtask

   // Called at a negedge; returns at the negedge of cycle 1.
   task automatic acceptJob(input int budget);
      int n = 0;
      while (!ifc.job_ready && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("accept_to", 64'(n < budget), 1);
      @(posedge clk);
      @(negedge clk);
      ifc.job_valid = 1'b0;
   endtask

   task automatic waitResult(input int budget);
      int n = 0;
      while (!ifc.result_valid && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("res_to", 64'(ifc.result_valid), 1);
   endtask

   task automatic waitAddr(input logic [6:0] a,
                           input int budget);
      int n = 0;
      while (ifc.bus_addr != a && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("addr_to", 64'(ifc.bus_addr), 64'(a));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      ifc.job_valid      = 1'b0;
      ifc.job_midstate   = '0;
      ifc.job_next_input = '0;
      ifc.job_difficulty = '0;
      ifc.job_abort      = 1'b0;
      ifc.result_ready   = 1'b0;
      for (int i = 0; i < 32; i++)
         jobA.midstate[8*i +: 8] = 8'(i);
      for (int j = 0; j < 12; j++)
         jobA.nextInput[8*j +: 8] = 8'(8'h80 + j);
      jobA.difficulty = 32'hDEADBEEF;
      jobB = '{32'h01020304, {3{32'hCAFEF00D}},
               {8{32'h5A5AA5A5}}};
      for (int i = 0; i < 12; i++)
         jobC[32*i +: 32] = $urandom;

      repeat (3) @(negedge clk);
      checkReset("rst");
      rst_n = 1'b1;
      @(negedge clk);

      // Load pattern + nonce found on the third poll.
      nonceVal    = 32'h12345678;
      statusFound = 1'b0;
      driveJob(jobA);
      expRes.push_back('{32'h12345678, 1'b0});
      acceptJob(4);
      check("first_addr", 64'(ifc.bus_addr), 5);
      check("first_oe", 64'(ifc.bus_wdata_oe), 1);
      repeat (95) @(negedge clk);
      check("c96_addr", 64'(ifc.bus_addr), 52);
      check("c96_oe", 64'(ifc.bus_wdata_oe), 1);
      @(negedge clk);
      check("c97_addr", 64'(ifc.bus_addr), 0);
      check("c97_oe", 64'(ifc.bus_wdata_oe), 0);
      repeat (39) @(negedge clk);
      statusFound = 1'b1;
      waitResult(200);
      check("m5", 64'(mem[5]), 8'h00);
      check("m36", 64'(mem[36]), 8'h1F);
      check("m37", 64'(mem[37]), 8'h80);
      check("m48", 64'(mem[48]), 8'h8B);
      check("m49", 64'(mem[49]), 8'hEF);
      check("m52", 64'(mem[52]), 8'hDE);
      check("rd_n", 64'(rdLog.size()), 4);
      for (int i = 0; i < 4 && i < rdLog.size(); i++)
         check("rd_seq", 64'(rdLog[i]), 64'(i + 1));

      // Backpressure with a new job already offered.
      statusFound = 1'b0;
      driveJob(jobB);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("bp_rv", 64'(ifc.result_valid), 1);
         check("bp_rn", 64'(ifc.result_nonce), 32'h12345678);
         check("bp_rdy", 64'(ifc.job_ready), 0);
      end
      ifc.result_ready = 1'b1;
      @(negedge clk);
      ifc.result_ready = 1'b0;
      check("rel_rv", 64'(ifc.result_valid), 0);
      check("rel_rdy", 64'(ifc.job_ready), 1);
      acceptJob(1);
      check("b_addr", 64'(ifc.bus_addr), 5);

      // Abort at write index 10.
      waitAddr(7'd15, 64);
      ifc.job_abort = 1'b1;
      @(negedge clk);
      ifc.job_abort = 1'b0;
      check("ab_addr", 64'(ifc.bus_addr), 0);
      check("ab_oe", 64'(ifc.bus_wdata_oe), 0);
      check("ab_rv", 64'(ifc.result_valid), 0);
      check("ab_rdy", 64'(ifc.job_ready), 1);
      check("ab_wr", 64'(wrCount), 11);
      expWr.delete();
      repeat (4) @(negedge clk);
      check("ab_idle", 64'(ifc.bus_addr), 0);

      // Full reload after abort, found on first poll.
      nonceVal = 32'hA5C30F96;
      ifc.result_ready = 1'b1;
      driveJob(jobC);
      expRes.push_back('{32'hA5C30F96, 1'b0});
      acceptJob(4);
      repeat (100) @(negedge clk);
      check("c_wr", 64'(wrCount), 48);
      statusFound = 1'b1;
      waitResult(200);
      @(negedge clk);
      check("c_ret", 64'(ifc.result_valid), 0);
      ifc.result_ready = 1'b0;

      // Asynchronous reset during the nonce read.
      driveJob(jobA);
      acceptJob(4);
      waitAddr(7'd2, 300);
      #2 rst_n = 1'b0;
      #1 checkReset("arst");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("arst_rdy", 64'(ifc.job_ready), 1);

      // Polling with status held low.
      statusFound = 1'b0;
      driveJob(jobB);
`ifdef JOB_TIMEOUT_EN
      expRes.push_back('{32'h0, 1'b1});
      acceptJob(4);
      waitResult(96 + 4 * 16 + 40);
      check("to_rd", 64'(rdLog.size()), 0);
      ifc.result_ready = 1'b1;
      @(negedge clk);
      ifc.result_ready = 1'b0;
      check("to_ret", 64'(ifc.job_ready), 1);
`else
      acceptJob(4);
      repeat (96 + 1000 * 16 + 32) @(negedge clk);
      check("poll_rv", 64'(ifc.result_valid), 0);
      check("poll_addr", 64'(ifc.bus_addr), 0);
      check("poll_rdy", 64'(ifc.job_ready), 0);
      check("poll_rd", 64'(rdLog.size()), 0);
      ifc.job_abort = 1'b1;
      @(negedge clk);
      ifc.job_abort = 1'b0;
      check("poll_ab", 64'(ifc.job_ready), 1);
`endif

      check("wr_left", 64'(expWr.size()), 0);
      check("res_left", 64'(expRes.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/job_bus_master.md
# job_bus_master

Initiator for the miner's 8-bit register bus. It accepts one hashing job (midstate, next input, difficulty) over a valid/ready handshake and writes it byte by byte into the responder's write-only registers. It then polls the status register until a nonce is found and reads back the 4 nonce bytes. The block sits between the host-side job source and the register-bus responder in front of the hashing core.

## Interface
Parameters:
- ACCESS_CYCLES, 2: cycles per bus access; legal values are 2 to 15.
- POLL_INTERVAL, 16: cycles between status samples; minimum 1.
- POLL_TIMEOUT, 1024: maximum number of status polls before timeout. 16-bit. Used only with JOB_TIMEOUT_EN.

Ports:
- clk, in, 1: single clock.
- rst_n, in, 1: asynchronous, active-low reset.
- job_valid, in, 1: a job is offered.
- job_ready, out, 1: high only in IDLE. A job is accepted when job_valid && job_ready.
- job_midstate, in, 256: midstate to load.
- job_next_input, in, 96: next-input words to load.
- job_difficulty, in, 32: difficulty target to load.
- job_abort, in, 1: cancels the job in flight.
- bus_addr, out, 7: register address.
- bus_wdata, out, 8: write byte.
- bus_wdata_oe, out, 1: drive enable for the shared data pins. The top level builds the tristate from this.
- bus_rdata, in, 8: byte read from the data pins.
- result_valid, out, 1: result available; held until accepted.
- result_ready, in, 1: consumer accepts the result.
- result_nonce, out, 32: nonce that was found.
- result_timeout, out, 1: the job ended by timeout.

## Operation
- Register map (responder side):
  - addr 0: status. status[0] = nonce found.
  - addr 1–4: nonce bytes [7:0] .. [31:24].
  - addr 5–36: midstate, ascending, addr 5 = bits [7:0].
  - addr 37–48: next input, same ordering.
  - addr 49–52: difficulty, same ordering.
- The responder writes whenever bus_addr is in 5–52. bus_addr must therefore sit at 0 whenever no write is intended.
- IDLE:
  - bus_addr = 0, bus_wdata_oe = 0.
  - On job acceptance, latch all job fields and go to WRITE with byte index 0.
- WRITE:
  - bus_addr = 5 + index; bus_wdata = byte[index] of the concatenation {difficulty, next_input, midstate}, with index 0 = midstate[7:0].
  - bus_wdata_oe = 1.
  - Each address is held for ACCESS_CYCLES cycles. After index 47 the block goes to POLL.
- POLL:
  - bus_addr = 0, bus_wdata_oe = 0.
  - A poll counter counts POLL_INTERVAL cycles, then the block samples bus_rdata.
  - If bit 0 is set, go to NONCE_RD with index 0. Otherwise restart the counter.
- NONCE_RD:
  - bus_addr = 1 + index. bus_rdata is sampled on the last cycle of each access into result_nonce[8*index +: 8].
  - After index 3, go to RESULT.
- RESULT:
  - result_valid = 1 and bus_addr = 0.
  - On result_ready, clear result_valid and go to IDLE.
- job_abort in WRITE, POLL or NONCE_RD:
  - The next cycle is IDLE with bus_addr = 0, bus_wdata_oe = 0 and no result.
  - A partial load stays in the responder; the next job rewrites all 48 bytes.
- job_abort in RESULT or IDLE is ignored. A result is only retired by result_ready.
- A new job is not accepted until the pending result is consumed.
- result_nonce is cleared to 0 on entry to NONCE_RD.

## Timing
- Reset values:
  - state IDLE, bus_addr 0, bus_wdata 0, bus_wdata_oe 0.
  - job_ready 1 (combinational from state).
  - result_valid 0, result_nonce 0, result_timeout 0.
- Reset asserted mid-operation returns to these values immediately (asynchronous).
- bus_addr, bus_wdata and bus_wdata_oe are registered and change together on one edge. No cycle may present a new address with stale data.
- Acceptance is in cycle 0; the first write (addr 5) is presented in cycle 1.
- The load takes 48 × ACCESS_CYCLES cycles (96 at default). POLL starts in cycle 97.
- Status is sampled POLL_INTERVAL cycles after POLL entry.
- Reading the nonce takes 4 × ACCESS_CYCLES cycles.
- result_valid rises 1 cycle after the last nonce sample.

## Configuration
- JOB_TIMEOUT_EN defined:
  - POLL counts status samples.
  - After POLL_TIMEOUT samples without status[0], go to RESULT with result_nonce = 0 and result_timeout = 1. No nonce reads are performed.
  - A successful poll on the final sample wins: the block reads the nonce and reports result_timeout = 0.
- JOB_TIMEOUT_EN undefined:
  - POLL runs indefinitely.
  - result_timeout is tied to 0; the port remains.

## Structure
- Shared package mining_bus_pkg holds:
  - the address constants ADDR_STATUS = 0, ADDR_NONCE0 = 1, ADDR_MIDSTATE0 = 5, ADDR_NEXTINPUT0 = 37, ADDR_DIFFICULTY0 = 49, ADDR_LAST = 52;
  - JOB_BYTES = 48 and STATUS_FOUND_BIT = 0;
  - the state enum (IDLE, WRITE, POLL, NONCE_RD, RESULT).
- The responder uses the same package.
- One natural sub-module, bus_access_timer: down-counter producing the last-cycle-of-access strobe, shared by WRITE and NONCE_RD.

## Test plan
- Load pattern: job with midstate byte i = i, next_input byte j = 0x80+j, difficulty = 0xDEADBEEF, default parameters.
  - Responder model captures addr 5 = 0x00, addr 36 = 0x1F, addr 37 = 0x80, addr 48 = 0x8B, addr 49 = 0xEF, addr 52 = 0xDE.
  - bus_wdata_oe is low by cycle 97.
- Found nonce: status = 0x01 on the 3rd poll with nonce 0x12345678.
  - result_nonce = 0x12345678, result_timeout = 0.
  - The bus read addresses 1, 2, 3, 4 in order.
- Backpressure: hold result_ready low for 20 cycles with job_valid high.
  - result_valid and result_nonce stay stable; job_ready stays 0.
  - Release result_ready: IDLE next cycle, and the new job is accepted the cycle after.
- Abort at write index 10: the next cycle has bus_addr = 0 and oe = 0, with no result_valid.
  - A following job writes all 48 bytes again.
- Timeout (JOB_TIMEOUT_EN, POLL_TIMEOUT = 4, status held at 0): result_valid after 4 samples with result_timeout = 1 and result_nonce = 0.
  - With the macro undefined, the block is still polling after 1000 samples.
- Asynchronous reset pulse during NONCE_RD: all outputs return to reset values with no clock edge; job_ready = 1 after release.
